clock_divider_bank: RTL and testbench

- Bank of CHANNELS independent programmable clock dividers, all running from one input clock.
- Each channel produces a registered divided clock-enable style square wave and a one-cycle tick aligned to its rising edge.
- Divisors are runtime-writable through a simple write port; changes apply at period boundaries so no runt pulses occur.
- A global sync input phase-aligns all channels.
- Serves as the programmable successor to the fixed power-of-two prescaler for peripherals that need arbitrary baud or sample rates.

---
 rtl/clock_divider_bank_if.sv | 18 +
 rtl/clock_divider_bank.sv | 91 +++++++++
 tb/tb_clock_divider_bank.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_divider_bank_if.sv
// Divisor write port shared by all channels of clock_divider_bank.
//   wr_en   : divisor write strobe
//   wr_ch   : target channel index (indices >= CHANNELS are ignored by the bank)
//   wr_data : divisor value D (period = D + 2 input cycles)
// master drives the write port, slave (the divider bank) receives it.
interface clock_divider_bank_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
);
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             wr_en;
  logic [CHW-1:0]   wr_ch;
  logic [WIDTH-1:0] wr_data;

  modport master (output wr_en, wr_ch, wr_data);
  modport slave  (input  wr_en, wr_ch, wr_data);
endinterface

// File: rtl/clock_divider_bank.sv
// Bank of CHANNELS independent programmable clock dividers on one input clock.
// Each channel outputs a registered square wave (period A+2, high floor(P/2))
// and a one-cycle tick on every rising edge of that wave. New divisors are
// staged in a shadow register and only become active at a period boundary
// (wrap, sync, start or while disabled), so no runt pulses are produced.
//   clk    : input clock, all logic on posedge
//   reset  : synchronous, active-high
//   en     : per-channel enable
//   sync   : global phase-align strobe, restarts all enabled channels
//   wr     : divisor write port (slave modport)
//   clkout : divided clock per channel, registered
//   tick   : one-cycle pulse on each rising edge of clkout
module clock_divider_bank #(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 16,
  parameter int RESET_DIV = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CHANNELS-1:0]  en,
  input  logic                 sync,
  clock_divider_bank_if.slave  wr,
  output logic [CHANNELS-1:0]  clkout,
  output logic [CHANNELS-1:0]  tick
);
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH:0]   c_q, c_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;
    logic             en_prev_q;

    logic             wr_hit;
    logic [WIDTH-1:0] load;
    logic [WIDTH:0]   last;   // P-1 = A+1
    logic [WIDTH:0]   high;   // H = floor((A+2)/2)
    logic [WIDTH:0]   c_inc;

    // Out-of-range channel indices never match any gi, so they are dropped.
    assign wr_hit = wr.wr_en && (wr.wr_ch == CHW'(gi));
    // Write-through: a write landing on a load cycle is used immediately.
    assign load   = wr_hit ? wr.wr_data : s_q;
    // WIDTH+1 bits so A = all-ones still yields P = 2^WIDTH+1 without overflow.
    assign last   = {1'b0, a_q} + (WIDTH+1)'(1);
    assign high   = ({1'b0, a_q} + (WIDTH+1)'(2)) >> 1;
    assign c_inc  = c_q + (WIDTH+1)'(1);

    always_comb begin
      s_d    = wr_hit ? wr.wr_data : s_q;
      a_d    = a_q;
      c_d    = c_inc;
      out_d  = (c_inc < high);
      tick_d = 1'b0;
      if (!en[gi]) begin
        c_d    = '0;
        a_d    = load;
        out_d  = 1'b0;
        tick_d = 1'b0;
      end else if (sync || !en_prev_q || (c_q == last)) begin
        c_d    = '0;
        a_d    = load;
        out_d  = 1'b1;
        tick_d = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        s_q       <= WIDTH'(RESET_DIV);
        a_q       <= WIDTH'(RESET_DIV);
        c_q       <= '0;
        out_q     <= 1'b0;
        tick_q    <= 1'b0;
        en_prev_q <= 1'b0;
      end else begin
        s_q       <= s_d;
        a_q       <= a_d;
        c_q       <= c_d;
        out_q     <= out_d;
        tick_q    <= tick_d;
        en_prev_q <= en[gi];
      end
    end

    assign clkout[gi] = out_q;
    assign tick[gi]   = tick_q;
  end
endmodule

// File: tb/tb_clock_divider_bank.sv
module tb_clock_divider_bank;
  logic       clk;
  logic       reset;
  logic [3:0] en;
  logic       sync;
  logic [3:0] clkout;
  logic [3:0] tick;
  logic [2:0] en2;
  logic [2:0] clkout2;
  logic [2:0] tick2;

  int checks;
  int failures;

  clock_divider_bank_if #(.CHANNELS(4), .WIDTH(16)) wif ();
  clock_divider_bank_if #(.CHANNELS(3), .WIDTH(4))  wif2 ();

  clock_divider_bank #(.CHANNELS(4), .WIDTH(16), .RESET_DIV(0)) dut (
    .clk(clk), .reset(reset), .en(en), .sync(sync), .wr(wif),
    .clkout(clkout), .tick(tick)
  );

  clock_divider_bank #(.CHANNELS(3), .WIDTH(4), .RESET_DIV(0)) dut2 (
    .clk(clk), .reset(reset), .en(en2), .sync(sync), .wr(wif2),
    .clkout(clkout2), .tick(tick2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr1(input logic [1:0] ch, input logic [15:0] d);
    wif.wr_en = 1'b1; wif.wr_ch = ch; wif.wr_data = d;
    step();
    wif.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    logic e;
    reset = 1'b1; en = 4'b0001; sync = 1'b0; en2 = '0;
    wif.wr_en = 1'b0; wif.wr_ch = '0; wif.wr_data = '0;
    wif2.wr_en = 1'b0; wif2.wr_ch = '0; wif2.wr_data = '0;
    step(); step();
    checks++;
    if (clkout !== 4'b0000 || tick !== 4'b0000 || clkout2 !== 3'b000 || tick2 !== 3'b000) begin
      failures++;
      $display("FAIL reset_state: clkout=%b tick=%b clkout2=%b tick2=%b required all zero",
               clkout, tick, clkout2, tick2);
    end
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      e = (k % 2 == 0);
      checks++;
      if (clkout !== {3'b000, e} || tick !== {3'b000, e}) begin
        failures++;
        $display("FAIL div2_after_reset k=%0d: clkout=%b tick=%b required %b/%b",
                 k, clkout, tick, {3'b000, e}, {3'b000, e});
      end
    end
  endtask

  task automatic test_div_change();
    logic        e;
    logic [11:0] ec;
    logic [11:0] et;
    en = 4'b0000;
    wr1(2'd1, 16'd1);
    en = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      step();
      e = (k % 3 == 0);
      checks++;
      if (clkout !== {2'b00, e, 1'b0} || tick !== {2'b00, e, 1'b0}) begin
        failures++;
        $display("FAIL div3 k=%0d: clkout=%b tick=%b required %b/%b",
                 k, clkout, tick, {2'b00, e, 1'b0}, {2'b00, e, 1'b0});
      end
    end
    ec = 12'b001110001110;
    et = 12'b001000001000;
    for (int k = 0; k < 12; k++) begin
      if (k == 0) begin wif.wr_en = 1'b1; wif.wr_ch = 2'd1; wif.wr_data = 16'd4; end
      if (k == 1) wif.wr_en = 1'b0;
      step();
      checks++;
      if (clkout !== {2'b00, ec[11-k], 1'b0} || tick !== {2'b00, et[11-k], 1'b0}) begin
        failures++;
        $display("FAIL div6_change k=%0d: clkout=%b tick=%b required %b/%b",
                 k, clkout, tick, {2'b00, ec[11-k], 1'b0}, {2'b00, et[11-k], 1'b0});
      end
    end
  endtask

  task automatic test_midperiod_write();
    logic [14:0] ec;
    logic [14:0] et;
    logic [12:0] fc;
    logic [12:0] ft;
    en = 4'b0000;
    wr1(2'd2, 16'd2);
    en = 4'b0100;
    ec = 15'b110011111000001;
    et = 15'b100010000000001;
    for (int k = 0; k < 15; k++) begin
      if (k == 1) begin wif.wr_en = 1'b1; wif.wr_ch = 2'd2; wif.wr_data = 16'd8; end
      if (k == 2) wif.wr_en = 1'b0;
      step();
      checks++;
      if (clkout !== {1'b0, ec[14-k], 2'b00} || tick !== {1'b0, et[14-k], 2'b00}) begin
        failures++;
        $display("FAIL midperiod_write k=%0d: clkout=%b tick=%b required %b/%b",
                 k, clkout, tick, {1'b0, ec[14-k], 2'b00}, {1'b0, et[14-k], 2'b00});
      end
    end
    fc = 13'b1111000001010;
    ft = 13'b0000000001010;
    for (int k = 0; k < 13; k++) begin
      if (k == 9) begin wif.wr_en = 1'b1; wif.wr_ch = 2'd2; wif.wr_data = 16'd0; end
      if (k == 10) wif.wr_en = 1'b0;
      step();
      checks++;
      if (clkout !== {1'b0, fc[12-k], 2'b00} || tick !== {1'b0, ft[12-k], 2'b00}) begin
        failures++;
        $display("FAIL wrap_write k=%0d: clkout=%b tick=%b required %b/%b",
                 k, clkout, tick, {1'b0, fc[12-k], 2'b00}, {1'b0, ft[12-k], 2'b00});
      end
    end
  endtask

  task automatic test_sync();
    logic [5:0] c0;
    logic [5:0] c3;
    logic [5:0] t0;
    logic [5:0] t3;
    en = 4'b0000;
    wr1(2'd0, 16'd1);
    wr1(2'd3, 16'd3);
    en = 4'b0001;
    step(); step();
    en = 4'b1001;
    step(); step(); step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    checks++;
    if (clkout !== 4'b1001 || tick !== 4'b1001) begin
      failures++;
      $display("FAIL sync_align: clkout=%b tick=%b required 1001/1001", clkout, tick);
    end
    c0 = 6'b100100; t0 = 6'b100100;
    c3 = 6'b110001; t3 = 6'b100001;
    for (int k = 1; k < 6; k++) begin
      step();
      checks++;
      if (clkout !== {c3[5-k], 2'b00, c0[5-k]} || tick !== {t3[5-k], 2'b00, t0[5-k]}) begin
        failures++;
        $display("FAIL after_sync k=%0d: clkout=%b tick=%b required %b/%b",
                 k, clkout, tick, {c3[5-k], 2'b00, c0[5-k]}, {t3[5-k], 2'b00, t0[5-k]});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic e;
    en = 4'b0000;
    wr1(2'd1, 16'd5);
    en = 4'b0010;
    step(); step();
    checks++;
    if (clkout !== 4'b0010) begin
      failures++;
      $display("FAIL pre_reset_high: clkout=%b required 0010", clkout);
    end
    reset = 1'b1;
    step();
    checks++;
    if (clkout !== 4'b0000 || tick !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid: clkout=%b tick=%b required 0000/0000", clkout, tick);
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      e = (k % 2 == 0);
      checks++;
      if (clkout !== {2'b00, e, 1'b0} || tick !== {2'b00, e, 1'b0}) begin
        failures++;
        $display("FAIL post_reset_div2 k=%0d: clkout=%b tick=%b required %b/%b",
                 k, clkout, tick, {2'b00, e, 1'b0}, {2'b00, e, 1'b0});
      end
    end
  endtask

  task automatic test_disable();
    en = 4'b0000;
    wr1(2'd0, 16'd2);
    en = 4'b0001;
    step(); step(); step();
    en = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (clkout !== 4'b0000 || tick !== 4'b0000) begin
        failures++;
        $display("FAIL disabled k=%0d: clkout=%b tick=%b required 0000/0000", k, clkout, tick);
      end
    end
    en = 4'b0001;
    step();
    checks++;
    if (clkout !== 4'b0001 || tick !== 4'b0001) begin
      failures++;
      $display("FAIL reenable_tick: clkout=%b tick=%b required 0001/0001", clkout, tick);
    end
    step();
    checks++;
    if (clkout !== 4'b0001 || tick !== 4'b0000) begin
      failures++;
      $display("FAIL reenable_high2: clkout=%b tick=%b required 0001/0000", clkout, tick);
    end
    step();
    checks++;
    if (clkout !== 4'b0000 || tick !== 4'b0000) begin
      failures++;
      $display("FAIL reenable_low: clkout=%b tick=%b required 0000/0000", clkout, tick);
    end
  endtask

  task automatic test_width4();
    logic e0, t0, e1;
    en2 = 3'b000;
    wif2.wr_en = 1'b1; wif2.wr_ch = 2'd0; wif2.wr_data = 4'd15;
    step();
    wif2.wr_ch = 2'd3; wif2.wr_data = 4'd7;
    step();
    wif2.wr_en = 1'b0;
    en2 = 3'b011;
    for (int k = 0; k < 18; k++) begin
      step();
      e0 = ((k % 17) < 8);
      t0 = ((k % 17) == 0);
      e1 = (k % 2 == 0);
      checks++;
      if (clkout2 !== {1'b0, e1, e0} || tick2 !== {1'b0, e1, t0}) begin
        failures++;
        $display("FAIL width4_div17 k=%0d: clkout=%b tick=%b required %b/%b",
                 k, clkout2, tick2, {1'b0, e1, e0}, {1'b0, e1, t0});
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_div_change();
    test_midperiod_write();
    test_sync();
    test_reset_mid();
    test_disable();
    test_width4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
